// File: rtl/load_unit.sv
// Memory-read sequencer: on a LOAD opcode it fetches the word at MAR through a
// req/gnt/rvalid handshake and hands it to the register-update hub as the new MDR.
module load_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter logic [7:0]  OP_LOAD = 8'h02,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [15:0]       instruction,
    input  logic [ADDR_W-1:0] mar_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] load_to_mdr,
    output logic              is_loaded,
    output logic              busy,
    output logic              load_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   mdr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mem_req_q;
    logic                busy_q;
    logic                is_loaded_q;
    logic                load_err_q;

    logic                accept;
    logic                expire;
    logic                unused_instr_lo;

    // The load_err cycle is an abort cycle and does not accept a new load.
    assign accept = issue && (instruction[15:8] == OP_LOAD) && !load_err_q &&
                    ((state_q == IDLE) || (state_q == DONE));

    // This cycle is the TIMEOUT-th busy cycle; a zero TIMEOUT never expires.
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign unused_instr_lo = ^instruction[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mdr_q       <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            is_loaded_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            is_loaded_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q   <= REQ;
                        addr_q    <= mar_in;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_gnt && mem_rvalid) begin
                        state_q     <= DONE;
                        mdr_q       <= mem_rdata;
                        is_loaded_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (expire) begin
                        state_q    <= IDLE;
                        load_err_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        if (mem_gnt) begin
                            state_q   <= WAIT;
                            mem_req_q <= 1'b0;
                        end
                        if (TIMEOUT != 0) cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= DONE;
                        mdr_q       <= mem_rdata;
                        is_loaded_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (expire) begin
                        state_q    <= IDLE;
                        load_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign load_to_mdr = mdr_q;
    assign is_loaded   = is_loaded_q;
    assign busy        = busy_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed scenarios plus randomized loads checked against
// a transaction-level latency/data model; a second instance uses TIMEOUT=4.
module tb_load_unit;

    localparam logic [7:0] OP_LOAD = 8'h02;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue = 1'b0;
    logic [15:0] instruction = '0;
    logic [15:0] mar_in = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;

    logic        a_mem_req, a_is_loaded, a_busy, a_load_err;
    logic [15:0] a_mem_addr, a_load_to_mdr;
    logic        b_mem_req, b_is_loaded, b_busy, b_load_err;
    logic [15:0] b_mem_addr, b_load_to_mdr;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_mdr = '0;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .issue(issue), .instruction(instruction), .mar_in(mar_in),
        .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .load_to_mdr(a_load_to_mdr), .is_loaded(a_is_loaded),
        .busy(a_busy), .load_err(a_load_err)
    );

    load_unit #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .issue(issue), .instruction(instruction), .mar_in(mar_in),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .load_to_mdr(b_load_to_mdr), .is_loaded(b_is_loaded),
        .busy(b_busy), .load_err(b_load_err)
    );

    task automatic step;
        @(negedge clk);
    endtask

    // One load: gnt after g stalled REQ cycles, rvalid r cycles after gnt.
    // Expected: issue at N, REQ during N+1..N+1+g, is_loaded exactly at N+2+g+r.
    task automatic run_load(input logic [15:0] instr, input logic [15:0] addr,
                            input logic [15:0] data, input int g, input int r, input bit noise);
        issue = 1'b1; instruction = instr; mar_in = addr;
        step;
        issue = 1'b0;
        for (int i = 0; i <= g; i++) begin
            checks++;
            if ({a_mem_req, a_busy, a_is_loaded, a_mem_addr} !== {3'b110, addr}) begin
                errors++;
                $display("FAIL req_phase: req/busy/ld=%b%b%b addr=%h, want 110 addr=%h",
                         a_mem_req, a_busy, a_is_loaded, a_mem_addr, addr);
            end
            mem_gnt    = (i == g);
            mem_rvalid = (i == g) ? (r == 0) : (noise && $urandom_range(0, 1) == 1);
            mem_rdata  = (i == g && r == 0) ? data : 16'($urandom);
            if (noise) begin
                issue = 1'($urandom); instruction = {OP_LOAD, 8'($urandom)}; mar_in = 16'($urandom);
            end
            step;
        end
        mem_gnt = 1'b0;
        for (int j = 1; j <= r; j++) begin
            checks++;
            if ({a_mem_req, a_busy, a_is_loaded} !== 3'b010) begin
                errors++;
                $display("FAIL wait_phase: req/busy/ld=%b%b%b, want 010", a_mem_req, a_busy, a_is_loaded);
            end
            mem_rvalid = (j == r);
            mem_rdata  = (j == r) ? data : 16'($urandom);
            if (noise) begin
                issue = 1'($urandom); instruction = {OP_LOAD, 8'($urandom)}; mar_in = 16'($urandom);
            end
            step;
        end
        mem_rvalid = 1'b0; issue = 1'b0;
        checks++;
        if ({a_mem_req, a_busy, a_is_loaded, a_load_to_mdr} !== {3'b001, data}) begin
            errors++;
            $display("FAIL done_phase: req/busy/ld=%b%b%b mdr=%h, want 001 mdr=%h",
                     a_mem_req, a_busy, a_is_loaded, a_load_to_mdr, data);
        end
        exp_mdr = data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step; step;
        checks++;
        if ({a_mem_req, a_busy, a_is_loaded, a_load_err, a_mem_addr, a_load_to_mdr,
             b_mem_req, b_busy, b_is_loaded, b_load_err, b_mem_addr, b_load_to_mdr} !== '0) begin
            errors++;
            $display("FAIL reset_values: a=%b%b%b%b %h %h b=%b%b%b%b %h %h, want all zero",
                     a_mem_req, a_busy, a_is_loaded, a_load_err, a_mem_addr, a_load_to_mdr,
                     b_mem_req, b_busy, b_is_loaded, b_load_err, b_mem_addr, b_load_to_mdr);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_zero_wait;
        run_load(16'h0210, 16'h0040, 16'hBEEF, 0, 0, 1'b0);
        step;
        checks++;
        if ({a_busy, a_is_loaded, a_load_to_mdr} !== {2'b00, 16'hBEEF}) begin
            errors++;
            $display("FAIL zero_wait_after: busy/ld=%b%b mdr=%h, want 00 mdr=beef",
                     a_busy, a_is_loaded, a_load_to_mdr);
        end
    endtask

    task automatic test_stalled;
        run_load(16'h0233, 16'h0123, 16'h1234, 3, 2, 1'b0);
        step;
        checks++;
        if ({a_is_loaded, a_load_to_mdr} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL stalled_single_pulse: ld=%b mdr=%h, want 0 mdr=1234", a_is_loaded, a_load_to_mdr);
        end
    endtask

    task automatic test_non_load;
        issue = 1'b1; instruction = 16'h0110; mar_in = 16'h0077;
        step;
        issue = 1'b0;
        checks++;
        if ({a_mem_req, a_busy, a_is_loaded, a_load_to_mdr} !== {3'b000, exp_mdr}) begin
            errors++;
            $display("FAIL non_load: req/busy/ld=%b%b%b mdr=%h, want 000 mdr=%h",
                     a_mem_req, a_busy, a_is_loaded, a_load_to_mdr, exp_mdr);
        end
        mem_rvalid = 1'b1; mem_rdata = 16'hF00D;
        step;
        mem_rvalid = 1'b0;
        checks++;
        if ({a_mem_req, a_is_loaded, a_load_to_mdr} !== {2'b00, exp_mdr}) begin
            errors++;
            $display("FAIL idle_rvalid: req/ld=%b%b mdr=%h, want 00 mdr=%h",
                     a_mem_req, a_is_loaded, a_load_to_mdr, exp_mdr);
        end
    endtask

    task automatic test_back_to_back;
        run_load(16'h0201, 16'h0040, 16'hAAAA, 1, 1, 1'b1);
        run_load(16'h0202, 16'h0041, 16'h5555, 0, 2, 1'b1);
        step;
        checks++;
        if ({a_mem_req, a_busy, a_is_loaded, a_load_to_mdr} !== {3'b000, 16'h5555}) begin
            errors++;
            $display("FAIL b2b_idle: req/busy/ld=%b%b%b mdr=%h, want 000 mdr=5555",
                     a_mem_req, a_busy, a_is_loaded, a_load_to_mdr);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1: run_load({OP_LOAD, 8'($urandom)}, 16'($urandom), 16'($urandom),
                               $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
                2: begin
                    issue = 1'b1; mar_in = 16'($urandom);
                    instruction = {8'($urandom_range(3, 255)), 8'($urandom)};
                    step;
                    issue = 1'b0;
                    checks++;
                    if ({a_mem_req, a_busy, a_is_loaded, a_load_to_mdr} !== {3'b000, exp_mdr}) begin
                        errors++;
                        $display("FAIL rand_non_load: req/busy/ld=%b%b%b mdr=%h, want 000 mdr=%h",
                                 a_mem_req, a_busy, a_is_loaded, a_load_to_mdr, exp_mdr);
                    end
                end
                default: begin
                    mem_rvalid = 1'b1; mem_rdata = 16'($urandom); mem_gnt = 1'($urandom);
                    step;
                    mem_rvalid = 1'b0; mem_gnt = 1'b0;
                    checks++;
                    if ({a_mem_req, a_is_loaded, a_load_to_mdr} !== {2'b00, exp_mdr}) begin
                        errors++;
                        $display("FAIL rand_spurious_rvalid: req/ld=%b%b mdr=%h, want 00 mdr=%h",
                                 a_mem_req, a_is_loaded, a_load_to_mdr, exp_mdr);
                    end
                end
            endcase
        end
        step;
    endtask

    task automatic test_timeout;
        rst_n = 1'b0; step; rst_n = 1'b1; step;
        run_load(16'h0200, 16'h0060, 16'hCAFE, 0, 0, 1'b0);
        step;
        issue = 1'b1; instruction = 16'h0200; mar_in = 16'h0071;
        step;
        issue = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({b_mem_req, b_busy, b_load_err} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_busy%0d: req/busy/err=%b%b%b, want 110", i, b_mem_req, b_busy, b_load_err);
            end
            step;
        end
        checks++;
        if ({b_mem_req, b_busy, b_is_loaded, b_load_err, b_load_to_mdr} !== {4'b0001, 16'hCAFE}) begin
            errors++;
            $display("FAIL timeout_abort: req/busy/ld/err=%b%b%b%b mdr=%h, want 0001 mdr=cafe",
                     b_mem_req, b_busy, b_is_loaded, b_load_err, b_load_to_mdr);
        end
        step;
        checks++;
        if ({b_load_err, b_busy} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_strobe_width: err/busy=%b%b, want 00", b_load_err, b_busy);
        end
        issue = 1'b1; mar_in = 16'h0072;
        step;
        issue = 1'b0;
        checks++;
        if ({b_mem_req, b_mem_addr} !== {1'b1, 16'h0072}) begin
            errors++;
            $display("FAIL timeout_fresh_req: req=%b addr=%h, want 1 addr=0072", b_mem_req, b_mem_addr);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if ({b_is_loaded, b_load_err, b_load_to_mdr} !== {2'b10, 16'h5A5A}) begin
            errors++;
            $display("FAIL timeout_fresh_done: ld/err=%b%b mdr=%h, want 10 mdr=5a5a",
                     b_is_loaded, b_load_err, b_load_to_mdr);
        end
        step;
    endtask

    task automatic test_reset_mid_load;
        issue = 1'b1; instruction = 16'h0200; mar_in = 16'h0090;
        step;
        issue = 1'b0; mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        checks++;
        if ({a_mem_req, a_busy} !== 2'b01) begin
            errors++;
            $display("FAIL mid_wait: req/busy=%b%b, want 01", a_mem_req, a_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_req, a_busy, a_is_loaded, a_load_err, a_load_to_mdr, a_mem_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset_wait: req/busy/ld/err=%b%b%b%b mdr=%h addr=%h, want all zero",
                     a_mem_req, a_busy, a_is_loaded, a_load_err, a_load_to_mdr, a_mem_addr);
        end
        step; step;
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        step;
        mem_rvalid = 1'b0;
        checks++;
        if ({a_busy, a_is_loaded, a_load_to_mdr} !== 18'd0) begin
            errors++;
            $display("FAIL late_rvalid: busy/ld=%b%b mdr=%h, want 00 mdr=0000", a_busy, a_is_loaded, a_load_to_mdr);
        end
        issue = 1'b1; mar_in = 16'h00A0;
        step;
        issue = 1'b0;
        checks++;
        if ({a_mem_req, a_mem_addr} !== {1'b1, 16'h00A0}) begin
            errors++;
            $display("FAIL idle_after_reset: req=%b addr=%h, want 1 addr=00a0", a_mem_req, a_mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_req, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_req: req/busy=%b%b, want 00", a_mem_req, a_busy);
        end
        step;
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_stalled;
        test_non_load;
        test_back_to_back;
        test_random;
        test_timeout;
        test_reset_mid_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
